am2940_dma_sequencer: RTL and testbench

// Control sequencer sitting directly upstream of the AM2940 address generator.
// - Accepts a transfer command (control mode, start address, word count).
// - Drives the AM2940 instruction/data/carry inputs to load its registers.
// - Runs a memory req/ack handshake per word, stepping the AM2940 counters on each accepted beat.
// - Stops when the AM2940 reports done, or on abort or ack timeout.

---
 rtl/am2940_dma_sequencer.sv | 97 +++++++++
 tb/tb_am2940_dma_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/am2940_dma_sequencer.sv
// am2940_dma_sequencer: loads an AM2940 from a latched command, then runs one req/ack memory beat per word until done, abort or timeout
module am2940_dma_sequencer #(
  parameter int DATA_LENGTH  = 8,
  parameter int CTRL_LENGTH  = 3,
  parameter int INSTR_LENGTH = 3,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CTRL_LENGTH-1:0]  cmd_ctrl,
  input  logic [DATA_LENGTH-1:0]  cmd_addr,
  input  logic [DATA_LENGTH-1:0]  cmd_wc,
  input  logic                    abort,
  output logic [INSTR_LENGTH-1:0] instruction,
  output logic [DATA_LENGTH-1:0]  data_out,
  output logic                    data_oe,
  output logic                    cinac,
  output logic                    cinwc,
  output logic                    oena,
  input  logic                    dma_done,
  input  logic [DATA_LENGTH-1:0]  dma_address,
  output logic                    mem_req,
  output logic [DATA_LENGTH-1:0]  mem_addr,
  input  logic                    mem_ack,
  output logic                    busy,
  output logic                    xfer_done,
  output logic                    timeout_err,
  output logic [DATA_LENGTH-1:0]  beat_cnt
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LD_CTRL, LD_ADDR, LD_WC, REQ, CHECK, ABORT} state_t;
  state_t state, nxt;
  logic [CTRL_LENGTH-1:0] ctrl_r;
  logic [DATA_LENGTH-1:0] addr_r, wc_r;
  logic [TW-1:0] tmo;
  logic beat;
  // abort outranks ack, so a coinciding abort never steps the AM2940 counters
  assign beat = state == REQ && mem_ack && !abort;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LD_CTRL : IDLE;
      LD_CTRL: nxt = LD_ADDR;
      LD_ADDR: nxt = LD_WC;
      LD_WC:   nxt = REQ;
      REQ:     nxt = mem_ack ? CHECK : tmo == '0 ? ABORT : REQ;
      CHECK:   nxt = dma_done ? IDLE : REQ;
      default: nxt = IDLE;
    endcase
    if (abort && state != IDLE) nxt = ABORT;
  end
  always_comb begin
    instruction = state == LD_CTRL ? INSTR_LENGTH'(0) :
                  state == LD_ADDR ? INSTR_LENGTH'(5) :
                  state == LD_WC   ? INSTR_LENGTH'(6) :
                  state == ABORT   ? INSTR_LENGTH'(4) : INSTR_LENGTH'(7);
    data_out    = state == LD_CTRL ? DATA_LENGTH'(ctrl_r) :
                  state == LD_ADDR ? addr_r :
                  state == LD_WC   ? wc_r : '0;
    data_oe     = state inside {LD_CTRL, LD_ADDR, LD_WC};
    cinac       = !beat;
    cinwc       = !beat;
    oena        = state != REQ;
    mem_req     = state == REQ;
    busy        = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ctrl_r      <= '0;
      addr_r      <= '0;
      wc_r        <= '0;
      tmo         <= '0;
      mem_addr    <= '0;
      beat_cnt    <= '0;
      timeout_err <= 1'b0;
      xfer_done   <= 1'b0;
    end else begin
      state     <= nxt;
      xfer_done <= state == CHECK && nxt == IDLE;
      if (state == IDLE && start) begin
        ctrl_r      <= cmd_ctrl;
        addr_r      <= cmd_addr;
        wc_r        <= cmd_wc;
        beat_cnt    <= '0;
        timeout_err <= 1'b0;
      end
      if (nxt == REQ && state != REQ) begin
        mem_addr <= dma_address;
        tmo      <= TW'(ACK_TIMEOUT - 1);
      end else if (state == REQ) tmo <= tmo - 1'b1;
      if (beat) beat_cnt <= beat_cnt + 1'b1;
      if (state == REQ && nxt == ABORT && !abort) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_am2940_dma_sequencer.sv
// tb_am2940_dma_sequencer: vector table plus directed multi-cycle sequences against a small AM2940 counter model
module tb_am2940_dma_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, mem_ack = 1'b0;
  logic [2:0] cmd_ctrl = '0;
  logic [7:0] cmd_addr = '0, cmd_wc = '0;
  logic [2:0] instruction;
  logic [7:0] data_out, mem_addr, beat_cnt, dma_address;
  logic data_oe, cinac, cinwc, oena, dma_done, mem_req, busy, xfer_done, timeout_err;
  logic [7:0] m_addr = '0, m_wc = '0;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  am2940_dma_sequencer #(.DATA_LENGTH(8), .CTRL_LENGTH(3), .INSTR_LENGTH(3), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_ctrl(cmd_ctrl), .cmd_addr(cmd_addr), .cmd_wc(cmd_wc),
    .abort(abort), .instruction(instruction), .data_out(data_out), .data_oe(data_oe), .cinac(cinac),
    .cinwc(cinwc), .oena(oena), .dma_done(dma_done), .dma_address(dma_address), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .busy(busy), .xfer_done(xfer_done),
    .timeout_err(timeout_err), .beat_cnt(beat_cnt));
  // AM2940 stand-in: address counts up, word count counts down, done at zero
  always @(posedge clk) begin
    if (instruction == 3'd5) m_addr <= data_out;
    else if (!cinac) m_addr <= m_addr + 8'd1;
    if (instruction == 3'd6) m_wc <= data_out;
    else if (!cinwc) m_wc <= m_wc - 8'd1;
  end
  assign dma_address = m_addr;
  assign dma_done = m_wc == 8'd0;
  typedef struct {
    logic st, ab, ack;
    logic [2:0] c;
    logic [7:0] a, w;
    logic [2:0] i;
    logic [7:0] d;
    logic oe, cin, oena, req;
    logic [7:0] ma;
    logic bsy, xd, te;
    logic [7:0] bc;
  } vec_t;
  vec_t tv[13];
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input vec_t v);
    chk({nm, ".instruction"}, 8'(instruction), 8'(v.i));
    chk({nm, ".data_out"}, data_out, v.d);
    chk({nm, ".data_oe"}, 8'(data_oe), 8'(v.oe));
    chk({nm, ".cinac"}, 8'(cinac), 8'(v.cin));
    chk({nm, ".cinwc"}, 8'(cinwc), 8'(v.cin));
    chk({nm, ".oena"}, 8'(oena), 8'(v.oena));
    chk({nm, ".mem_req"}, 8'(mem_req), 8'(v.req));
    chk({nm, ".mem_addr"}, mem_addr, v.ma);
    chk({nm, ".busy"}, 8'(busy), 8'(v.bsy));
    chk({nm, ".xfer_done"}, 8'(xfer_done), 8'(v.xd));
    chk({nm, ".timeout_err"}, 8'(timeout_err), 8'(v.te));
    chk({nm, ".beat_cnt"}, beat_cnt, v.bc);
  endtask
  task automatic go(input logic [2:0] c, input logic [7:0] a, input logic [7:0] w);
    start = 1'b1; cmd_ctrl = c; cmd_addr = a; cmd_wc = w;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  vec_t rv;
  int n;
  initial begin
    tv[0]  = '{1'b1,1'b0,1'b1,3'd1,8'h10,8'h03, 3'd7,8'h00,1'b0,1'b1,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd0};
    tv[1]  = '{1'b0,1'b0,1'b1,3'd1,8'h10,8'h03, 3'd0,8'h01,1'b1,1'b1,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0,8'd0};
    tv[2]  = '{1'b1,1'b0,1'b1,3'd5,8'h80,8'h09, 3'd5,8'h10,1'b1,1'b1,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0,8'd0};
    tv[3]  = '{1'b0,1'b0,1'b1,3'd1,8'h10,8'h03, 3'd6,8'h03,1'b1,1'b1,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0,8'd0};
    tv[4]  = '{1'b1,1'b0,1'b1,3'd5,8'h80,8'h09, 3'd7,8'h00,1'b0,1'b0,1'b0,1'b1,8'h10,1'b1,1'b0,1'b0,8'd0};
    tv[5]  = '{1'b0,1'b0,1'b1,3'd5,8'h80,8'h09, 3'd7,8'h00,1'b0,1'b1,1'b1,1'b0,8'h10,1'b1,1'b0,1'b0,8'd1};
    tv[6]  = '{1'b0,1'b0,1'b1,3'd5,8'h80,8'h09, 3'd7,8'h00,1'b0,1'b0,1'b0,1'b1,8'h11,1'b1,1'b0,1'b0,8'd1};
    tv[7]  = '{1'b0,1'b0,1'b1,3'd5,8'h80,8'h09, 3'd7,8'h00,1'b0,1'b1,1'b1,1'b0,8'h11,1'b1,1'b0,1'b0,8'd2};
    tv[8]  = '{1'b0,1'b0,1'b1,3'd5,8'h80,8'h09, 3'd7,8'h00,1'b0,1'b0,1'b0,1'b1,8'h12,1'b1,1'b0,1'b0,8'd2};
    tv[9]  = '{1'b0,1'b0,1'b1,3'd5,8'h80,8'h09, 3'd7,8'h00,1'b0,1'b1,1'b1,1'b0,8'h12,1'b1,1'b0,1'b0,8'd3};
    tv[10] = '{1'b0,1'b0,1'b1,3'd5,8'h80,8'h09, 3'd7,8'h00,1'b0,1'b1,1'b1,1'b0,8'h12,1'b0,1'b1,1'b0,8'd3};
    tv[11] = '{1'b0,1'b1,1'b0,3'd5,8'h80,8'h09, 3'd7,8'h00,1'b0,1'b1,1'b1,1'b0,8'h12,1'b0,1'b0,1'b0,8'd3};
    tv[12] = '{1'b0,1'b0,1'b0,3'd5,8'h80,8'h09, 3'd7,8'h00,1'b0,1'b1,1'b1,1'b0,8'h12,1'b0,1'b0,1'b0,8'd3};
    rv     = '{1'b0,1'b0,1'b0,3'd0,8'h00,8'h00, 3'd7,8'h00,1'b0,1'b1,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd0};
    repeat (2) @(negedge clk);
    #1 chk_all("reset", rv);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 13; k++) begin
      start = tv[k].st; abort = tv[k].ab; mem_ack = tv[k].ack;
      cmd_ctrl = tv[k].c; cmd_addr = tv[k].a; cmd_wc = tv[k].w;
      #1 chk_all($sformatf("vec%0d", k), tv[k]);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    go(3'd2, 8'h20, 8'h01);
    for (int k = 0; k < 5; k++) begin
      #1 chk("wait.mem_req", 8'(mem_req), 8'd1);
      chk("wait.mem_addr", mem_addr, 8'h20);
      chk("wait.cinac", 8'(cinac), 8'd1);
      @(negedge clk);
    end
    mem_ack = 1'b1;
    #1 chk("ack.cinac", 8'(cinac), 8'd0);
    chk("ack.cinwc", 8'(cinwc), 8'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1 chk("ack.check_req", 8'(mem_req), 8'd0);
    @(negedge clk);
    #1 chk("ack.xfer_done", 8'(xfer_done), 8'd1);
    chk("ack.beat_cnt", beat_cnt, 8'd1);
    go(3'd0, 8'h40, 8'h02);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      #1 if (!mem_req) break;
      n++;
      @(negedge clk);
    end
    chk("tmo.req_cycles", 8'(n), 8'd16);
    chk("tmo.instruction", 8'(instruction), 8'd4);
    chk("tmo.timeout_err", 8'(timeout_err), 8'd1);
    chk("tmo.cinac", 8'(cinac), 8'd1);
    @(negedge clk);
    #1 chk("tmo.busy", 8'(busy), 8'd0);
    chk("tmo.xfer_done", 8'(xfer_done), 8'd0);
    chk("tmo.sticky", 8'(timeout_err), 8'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 chk("tmo.cleared", 8'(timeout_err), 8'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1 chk("ldabort.instruction", 8'(instruction), 8'd4);
    @(negedge clk);
    #1 chk("ldabort.busy", 8'(busy), 8'd0);
    mem_ack = 1'b1;
    go(3'd1, 8'h30, 8'h03);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    #1 chk("abort.cinac", 8'(cinac), 8'd1);
    chk("abort.cinwc", 8'(cinwc), 8'd1);
    chk("abort.mem_req", 8'(mem_req), 8'd1);
    @(negedge clk);
    abort = 1'b0; mem_ack = 1'b0;
    #1 chk("abort.instruction", 8'(instruction), 8'd4);
    chk("abort.beat_cnt", beat_cnt, 8'd1);
    @(negedge clk);
    #1 chk("abort.busy", 8'(busy), 8'd0);
    chk("abort.xfer_done", 8'(xfer_done), 8'd0);
    mem_ack = 1'b1;
    go(3'd3, 8'h50, 8'h04);
    @(negedge clk);
    #1 chk("rst.pre_beat_cnt", beat_cnt, 8'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk_all("rst", rv);
    go(3'd1, 8'h60, 8'h01);
    #1 chk("post.mem_addr", mem_addr, 8'h60);
    chk("post.cinac", 8'(cinac), 8'd0);
    @(negedge clk);
    @(negedge clk);
    #1 chk("post.xfer_done", 8'(xfer_done), 8'd1);
    chk("post.beat_cnt", beat_cnt, 8'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
